// File: rtl/hub_linear_fold_ctrl.sv
// rtl/hub_linear_fold_ctrl.sv - control sequencer for a folded hybrid unary-binary linear layer
//
// Purpose: accepts a frame request, strobes a one-cycle weight load, then
// walks FOLD partition windows of CYCL bitstream cycles each. At every frame
// end it flips the double-buffer select and launches a done token that
// emerges LAT cycles later. Back-to-back frames skip the weight reload.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   start  in   frame request (sampled in IDLE and on the last frame cycle)
//   ready  out  high only in IDLE
//   load   out  weight-buffer capture strobe (LOAD state only)
//   part   out  active partition index
//   clear  out  clear accumulator of active partition (first cycle of window)
//   sel    out  double-buffer accumulate select
//   done   out  one-cycle pulse, frame activations valid
module hub_linear_fold_ctrl #(
  parameter int FOLD = 2,
  parameter int CYCL = 1024,
  parameter int LAT  = 2,
  parameter int PWID = (FOLD > 1) ? $clog2(FOLD) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            ready,
  output logic            load,
  output logic [PWID-1:0] part,
  output logic            clear,
  output logic            sel,
  output logic            done
);

  localparam int CWID = $clog2(CYCL);
  localparam int DWID = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CWID-1:0]   cnt;
  logic [PWID-1:0]   part_q;
  logic [DWID-1:0]   dcnt;
  logic              sel_q;
  logic [LAT-1:0]    done_sr;

  logic              cnt_wrap;
  logic              part_last;
  logic              frame_last;

  assign cnt_wrap   = (cnt == CWID'(CYCL - 1));
  assign part_last  = (part_q == PWID'(FOLD - 1));
  // Last cycle of a frame: the only RUN cycle where start is honoured.
  assign frame_last = (state == RUN) && cnt_wrap && part_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = RUN;
      RUN:   if (frame_last && !start) state_nxt = DRAIN;
      DRAIN: if (dcnt == DWID'(LAT - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state only; no path from start.
  always_comb begin
    ready = 1'b0;
    load  = 1'b0;
    clear = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      LOAD:    load  = 1'b1;
      RUN:     clear = (cnt == '0);
      default: ;
    endcase
  end

  // Window counter and partition index. A wrap on the last partition returns
  // to partition 0, which is both the back-to-back restart and the DRAIN hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      part_q <= '0;
    end else if (state == RUN) begin
      if (cnt_wrap) begin
        cnt <= '0;
        if (part_last) begin
          part_q <= '0;
        end else begin
          part_q <= part_q + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt    <= '0;
      part_q <= '0;
    end
  end

  // DRAIN duration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if (state == DRAIN) begin
      dcnt <= dcnt + 1'b1;
    end else begin
      dcnt <= '0;
    end
  end

  // Buffer select flips and a done token is launched at every frame end.
  // The shift register lets tokens of overlapping frames each emerge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      done_sr <= '0;
    end else begin
      if (frame_last) begin
        sel_q <= ~sel_q;
      end
      done_sr <= (done_sr << 1) | LAT'(frame_last);
    end
  end

  assign part = part_q;
  assign sel  = sel_q;
  assign done = done_sr[LAT-1];

endmodule

// File: tb/tb_hub_linear_fold_ctrl.sv
// tb/tb_hub_linear_fold_ctrl.sv - directed self-checking bench for hub_linear_fold_ctrl
module tb_hub_linear_fold_ctrl;

  logic clk;
  logic rst_n;
  logic start;
  logic start1;

  logic       ready, load, clear, sel, done;
  logic [0:0] part;
  logic       ready1, load1, clear1, sel1, done1;
  logic [0:0] part1;

  int total;
  int passed;

  logic [63:0] t_ready, t_load, t_part, t_clear, t_sel, t_done;
  logic [63:0] t1_ready, t1_load, t1_part, t1_clear, t1_sel, t1_done;

  hub_linear_fold_ctrl #(.FOLD(2), .CYCL(8), .LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .load  (load),
    .part  (part),
    .clear (clear),
    .sel   (sel),
    .done  (done)
  );

  hub_linear_fold_ctrl #(.FOLD(1), .CYCL(4), .LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .ready (ready1),
    .load  (load1),
    .part  (part1),
    .clear (clear1),
    .sel   (sel1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // mode 0: single pulse at 0; 1: held 0..48; 2: pulses in IDLE, LOAD, RUN cnt=3, DRAIN; else idle
  function automatic logic start_pat(input int mode, input int c);
    case (mode)
      0: return (c == 0);
      1: return (c <= 48);
      2: return (c == 0) || (c == 1) || (c == 5) || (c == 18);
      default: return 1'b0;
    endcase
  endfunction

  // Entered just after a rising edge; cycle c spans rising edge c to c+1.
  task automatic run_trace(input int mode, input int n);
    t_ready = '0; t_load = '0; t_part = '0; t_clear = '0; t_sel = '0; t_done = '0;
    t1_ready = '0; t1_load = '0; t1_part = '0; t1_clear = '0; t1_sel = '0; t1_done = '0;
    for (int c = 0; c < n; c++) begin
      start  = start_pat(mode, c);
      start1 = (mode == 0) && (c == 0);
      @(negedge clk);
      t_ready[c] = ready;  t_load[c] = load;  t_part[c] = part[0];
      t_clear[c] = clear;  t_sel[c]  = sel;   t_done[c] = done;
      t1_ready[c] = ready1; t1_load[c] = load1; t1_part[c] = part1[0];
      t1_clear[c] = clear1; t1_sel[c]  = sel1;  t1_done[c] = done1;
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_ctl"}, {59'd0, load, part[0], clear, sel, done}, 64'd0);
    chk({tag, "_ready1"}, {63'd0, ready1}, 64'd1);
    chk({tag, "_ctl1"}, {59'd0, load1, part1[0], clear1, sel1, done1}, 64'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;

    // Asynchronous reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle with start low
    run_trace(3, 20);
    chk("idle_ready", t_ready, rng(0, 19));
    chk("idle_ctl", t_load | t_part | t_clear | t_sel | t_done, 64'd0);
    chk("idle_ready1", t1_ready, rng(0, 19));

    // Single frame; FOLD=1 instance started alongside
    run_trace(0, 24);
    chk("one_load", t_load, rng(1, 1));
    chk("one_part", t_part, rng(10, 17));
    chk("one_clear", t_clear, rng(2, 2) | rng(10, 10));
    chk("one_sel", t_sel, rng(18, 23));
    chk("one_done", t_done, rng(19, 19));
    chk("one_ready", t_ready, rng(0, 0) | rng(20, 23));
    chk("f1_load", t1_load, rng(1, 1));
    chk("f1_part", t1_part, 64'd0);
    chk("f1_clear", t1_clear, rng(2, 2));
    chk("f1_done", t1_done, rng(6, 6));
    chk("f1_ready", t1_ready, rng(0, 0) | rng(7, 23));
    chk("f1_sel", t1_sel, rng(6, 23));

    // Three back-to-back frames; sel starts at 1
    run_trace(1, 56);
    chk("b2b_load", t_load, rng(1, 1));
    chk("b2b_done", t_done, rng(19, 19) | rng(35, 35) | rng(51, 51));
    chk("b2b_sel", t_sel, rng(0, 17) | rng(34, 49));
    chk("b2b_ready", t_ready, rng(0, 0) | rng(52, 55));
    chk("b2b_clear", t_clear, rng(2, 2) | rng(10, 10) | rng(18, 18) | rng(26, 26) | rng(34, 34) | rng(42, 42));
    chk("b2b_part", t_part, rng(10, 17) | rng(26, 33) | rng(42, 49));
    chk("b2b_f1_quiet", t1_sel, rng(0, 55));
    chk("b2b_f1_done", t1_done, 64'd0);

    // Ignored start pulses in LOAD, mid-RUN and DRAIN; sel starts at 0
    run_trace(2, 24);
    chk("ign_load", t_load, rng(1, 1));
    chk("ign_done", t_done, rng(19, 19));
    chk("ign_sel", t_sel, rng(18, 23));
    chk("ign_ready", t_ready, rng(0, 0) | rng(20, 23));
    chk("ign_part", t_part, rng(10, 17));

    // Reset at cycle 12 of a frame (sel is 1 before the frame)
    run_trace(0, 12);
    chk("mid_part_pre", t_part, rng(10, 11));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_trace(3, 30);
    chk("mid_no_done", t_done, 64'd0);
    chk("mid_sel", t_sel, 64'd0);
    chk("mid_no_load", t_load, 64'd0);
    chk("mid_ready", t_ready, rng(0, 29));
    run_trace(0, 4);
    chk("mid_reload", t_load, rng(1, 1));
    chk("mid_restart_clear", t_clear, rng(2, 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
